// File: rtl/mem_port_responder.sv
// Memory-side responder for the CPU instruction (A) and data (B) ports: round-robin
// arbitration onto one word-wide downstream memory, with a watchdog on the downstream response.
module mem_port_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read_a,
  input  logic [31:0] address_a,
  output logic        resp_a,
  output logic [31:0] rdata_a,
  input  logic        read_b,
  input  logic        write,
  input  logic [3:0]  wmask,
  input  logic [31:0] address_b,
  input  logic [31:0] wdata,
  output logic        resp_b,
  output logic [31:0] rdata_b,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  input  logic        mem_resp,
  input  logic [31:0] mem_rdata,
  output logic        err_timeout
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_A = 3'd1,
    BUSY_B = 3'd2,
    DONE_A = 3'd3,
    DONE_B = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_last_b;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wmask;
  logic        r_write;
  logic [31:0] r_wd_cnt;
  logic [31:0] r_rdata_a;
  logic [31:0] r_rdata_b;
  logic        r_err;

  logic        w_req_a;
  logic        w_req_b;
  logic        w_load;
  logic        w_grant_b;
  logic        w_busy;
  logic        w_expire;
  logic        w_finish;

  assign w_req_a  = read_a;
  assign w_req_b  = read_b | write;
  assign w_busy   = (r_state == BUSY_A) || (r_state == BUSY_B);
  assign w_expire = (TIMEOUT_CYCLES != 0) && w_busy && !mem_resp &&
                    (r_wd_cnt == 32'(TIMEOUT_CYCLES - 1));
  assign w_finish = w_busy && (mem_resp || w_expire);

  // Next-state and grant decision; contention goes to the port not served last
  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_grant_b = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req_a || w_req_b) begin
          w_load    = 1'b1;
          w_grant_b = (w_req_a && w_req_b) ? !r_last_b : w_req_b;
          w_next    = w_grant_b ? BUSY_B : BUSY_A;
        end
      end
      BUSY_A:  if (mem_resp || w_expire) w_next = DONE_A;
      BUSY_B:  if (mem_resp || w_expire) w_next = DONE_B;
      DONE_A:  w_next = IDLE;
      DONE_B:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_last_b  <= 1'b0;
      r_wd_cnt  <= '0;
      r_rdata_a <= '0;
      r_rdata_b <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_last_b <= w_grant_b;
        r_wd_cnt <= '0;
      end else if (w_busy) begin
        r_wd_cnt <= r_wd_cnt + 32'd1;
      end
      // A timed-out read returns zero rather than whatever the bus happens to carry
      if (w_finish && (r_state == BUSY_A)) begin
        r_rdata_a <= mem_resp ? mem_rdata : '0;
      end
      if (w_finish && (r_state == BUSY_B) && !r_write) begin
        r_rdata_b <= mem_resp ? mem_rdata : '0;
      end
      if (w_expire) begin
        r_err <= 1'b1;
      end
    end
  end

  // Request capture; only meaningful while BUSY, so no reset needed
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_addr  <= w_grant_b ? {address_b[31:2], 2'b00} : {address_a[31:2], 2'b00};
      r_write <= w_grant_b & write;
      r_wmask <= (w_grant_b & write) ? wmask : 4'b0000;
      r_wdata <= wdata;
    end
  end

  assign mem_read    = (r_state == BUSY_A) || ((r_state == BUSY_B) && !r_write);
  assign mem_write   = (r_state == BUSY_B) && r_write;
  assign mem_wmask   = mem_write ? r_wmask : 4'b0000;
  assign mem_wdata   = mem_write ? r_wdata : '0;
  assign mem_address = w_busy ? r_addr : '0;
  assign resp_a      = (r_state == DONE_A);
  assign resp_b      = (r_state == DONE_B);
  assign rdata_a     = r_rdata_a;
  assign rdata_b     = r_rdata_b;
  assign err_timeout = r_err;

  a_b_write_read_excl: assert property (@(posedge clk) disable iff (reset) !(write && read_b))
    else $error("port B write and read_b asserted together; write takes precedence");

endmodule
